// File: rtl/seg7_decoder.sv
// Recovers the hex digit shown on seven active-low segment lines. The lines are
// synchronized, filtered for stability, then decoded with a one-cycle strobe.
module seg7_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       leda,
    input  logic       ledb,
    input  logic       ledc,
    input  logic       ledd,
    input  logic       lede,
    input  logic       ledf,
    input  logic       ledg,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       blank,
    output logic       pattern_err,
    output logic [7:0] change_count
);
    // state  | meaning
    // TRACK  | candidate pattern still accumulating stable samples
    // LOCKED | candidate held STABLE_CYCLES samples and already committed
    typedef enum logic {TRACK, LOCKED} state_t;

    localparam logic [6:0] DARK      = 7'b1111111;
    localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [6:0] sync1, sync2;
    logic [6:0] cand_q, cand_d;
    logic [7:0] cnt_q, cnt_d;
    logic       commit;
    logic [6:0] last;
    logic       first;
    logic       hit;
    logic [3:0] value;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1 <= DARK;
            sync2 <= DARK;
        end else begin
            sync1 <= {leda, ledb, ledc, ledd, lede, ledf, ledg};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= TRACK;
            cand_q  <= DARK;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Commit fires on the edge where cnt reaches STABLE_CYCLES, so outputs
    // land on that same edge.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        if (sync2 != cand_q) begin
            cand_d  = sync2;
            cnt_d   = 8'd1;
            state_d = TRACK;
        end else begin
            case (state_q)
                TRACK: begin
                    cnt_d = 8'(cnt_q + 8'd1);
                    if (cnt_q == STABLE_M1) begin
                        state_d = LOCKED;
                        commit  = 1'b1;
                    end
                end
                LOCKED: begin
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = TRACK;
                end
            endcase
        end
    end

    always_comb begin
        hit   = 1'b1;
        value = 4'h0;
        case (cand_q)
            7'b0000001: value = 4'h0;
            7'b1001111: value = 4'h1;
            7'b0010010: value = 4'h2;
            7'b0000110: value = 4'h3;
            7'b1001100: value = 4'h4;
            7'b0100100: value = 4'h5;
            7'b0100000: value = 4'h6;
            7'b0001111: value = 4'h7;
            7'b0000000: value = 4'h8;
            7'b0000100: value = 4'h9;
            7'b0001000: value = 4'hA;
            7'b1100000: value = 4'hB;
            7'b0110001: value = 4'hC;
            7'b1000010: value = 4'hD;
            7'b0110000: value = 4'hE;
            7'b0111000: value = 4'hF;
            default:    hit   = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            digit        <= 4'h0;
            digit_valid  <= 1'b0;
            blank        <= 1'b0;
            pattern_err  <= 1'b0;
            change_count <= 8'd0;
            last         <= DARK;
            first        <= 1'b1;
        end else begin
            digit_valid <= 1'b0;
            pattern_err <= 1'b0;
            // A glitch that settles back to the accepted pattern stays silent.
            if (commit && (cand_q != last || first)) begin
                last  <= cand_q;
                first <= 1'b0;
                if (hit) begin
                    digit        <= value;
                    digit_valid  <= 1'b1;
                    blank        <= 1'b0;
                    change_count <= 8'(change_count + 8'd1);
                end else if (cand_q == DARK) begin
                    blank <= 1'b1;
                end else begin
                    pattern_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_decoder.sv
// Scoreboard bench for seg7_decoder: expected strobes are queued as patterns
// are driven and matched when digit_valid or pattern_err fires.
module tb_seg7_decoder;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [6:0] pins  = 7'b1111111;
    logic [3:0] digit;
    logic       digit_valid;
    logic       blank;
    logic       pattern_err;
    logic [7:0] change_count;

    seg7_decoder #(.STABLE_CYCLES(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .leda         (pins[6]),
        .ledb         (pins[5]),
        .ledc         (pins[4]),
        .ledd         (pins[3]),
        .lede         (pins[2]),
        .ledf         (pins[1]),
        .ledg         (pins[0]),
        .digit        (digit),
        .digit_valid  (digit_valid),
        .blank        (blank),
        .pattern_err  (pattern_err),
        .change_count (change_count)
    );

    always #5 clock = ~clock;

    localparam logic [6:0] DARK  = 7'b1111111;
    localparam logic [6:0] ODD_P = 7'b1111110;

    logic [6:0] codes [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    typedef struct {
        logic       is_err;
        logic [3:0] dig;
        logic [7:0] cnt;
    } ev_t;
    ev_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int err_seen = 0;

    logic [6:0] m_last;
    logic       m_first;
    logic       m_blank;
    logic [7:0] m_count;
    logic [3:0] m_digit;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_last  = DARK;
        m_first = 1'b1;
        m_blank = 1'b0;
        m_count = 8'd0;
        m_digit = 4'h0;
        exp_q.delete();
    endtask

    // Called when a pattern will be held long enough to commit.
    task automatic model_commit(input logic [6:0] pat);
        ev_t e;
        int  v;
        if (pat != m_last || m_first) begin
            m_last  = pat;
            m_first = 1'b0;
            v = -1;
            for (int i = 0; i < 16; i++) if (codes[i] == pat) v = i;
            if (v >= 0) begin
                m_count  = 8'(m_count + 8'd1);
                m_digit  = 4'(v);
                m_blank  = 1'b0;
                e.is_err = 1'b0;
                e.dig    = 4'(v);
                e.cnt    = m_count;
                exp_q.push_back(e);
            end else if (pat == DARK) begin
                m_blank = 1'b1;
            end else begin
                e.is_err = 1'b1;
                e.dig    = m_digit;
                e.cnt    = m_count;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic drive(input logic [6:0] pat, input int n);
        @(negedge clock);
        pins = pat;
        repeat (n) @(posedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_val("rst_digit", 32'(digit), 0);
        check_val("rst_valid", 32'(digit_valid), 0);
        check_val("rst_blank", 32'(blank), 0);
        check_val("rst_err", 32'(pattern_err), 0);
        check_val("rst_count", 32'(change_count), 0);
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    // Counts posedges from the drive edge until digit_valid is seen.
    task automatic measure_latency(output int lat);
        lat = -1;
        for (int e = 0; e < 20; e++) begin
            @(posedge clock);
            #1;
            if (digit_valid && lat < 0) lat = e;
        end
    endtask

    task automatic end_of_test(input string tag);
        check_val({tag, "_q_empty"}, 32'(exp_q.size()), 0);
        check_val({tag, "_digit"}, 32'(digit), 32'(m_digit));
        check_val({tag, "_blank"}, 32'(blank), 32'(m_blank));
        check_val({tag, "_count"}, 32'(change_count), 32'(m_count));
    endtask

    always @(negedge clock) begin
        if (digit_valid && pattern_err) check_val("both_strobes", 1, 0);
        if (pattern_err) err_seen++;
        if (digit_valid || pattern_err) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_strobe", 1, 0);
            end else begin
                automatic ev_t e = exp_q.pop_front();
                check_val("strobe_kind", 32'(pattern_err), 32'(e.is_err));
                check_val("strobe_digit", 32'(digit), 32'(e.dig));
                check_val("strobe_count", 32'(change_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        int lat;
        int err_before;
        model_reset();
        #1;
        check_val("init_digit", 32'(digit), 0);
        check_val("init_blank", 32'(blank), 0);
        check_val("init_count", 32'(change_count), 0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        model_commit(DARK);
        repeat (8) @(posedge clock);
        #1;
        check_val("dark_release_blank", 32'(blank), 32'(m_blank));

        model_commit(codes[3]);
        @(negedge clock);
        pins = codes[3];
        measure_latency(lat);
        check_val("latency_3", 32'(lat), 5);
        end_of_test("digit3");

        drive(ODD_P, 2);
        drive(codes[3], 10);
        check_val("glitch_err", 32'(err_seen), 0);
        end_of_test("glitch");

        model_commit(codes[5]);
        drive(codes[5], 8);
        model_commit(ODD_P);
        drive(ODD_P, 8);
        #1;
        check_val("err_digit_hold", 32'(digit), 5);
        check_val("err_blank_low", 32'(blank), 0);
        model_commit(DARK);
        drive(DARK, 8);
        #1;
        check_val("dark_blank", 32'(blank), 1);
        end_of_test("err_dark");

        do_reset();
        err_before = err_seen;
        for (int v = 0; v < 16; v++) begin
            model_commit(codes[v]);
            drive(codes[v], 8);
        end
        #1;
        check_val("sweep_count", 32'(change_count), 16);
        check_val("sweep_no_err", 32'(err_seen - err_before), 0);
        end_of_test("sweep");

        do_reset();
        for (int i = 0; i < 300; i++) begin
            model_commit(codes[(i % 2 == 0) ? 1 : 2]);
            drive(codes[(i % 2 == 0) ? 1 : 2], 6);
        end
        repeat (2) @(posedge clock);
        #1;
        check_val("wrap_count", 32'(change_count), 44);
        end_of_test("wrap");

        @(negedge clock);
        pins = codes[9];
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        check_val("mid_rst_digit", 32'(digit), 0);
        check_val("mid_rst_count", 32'(change_count), 0);
        check_val("mid_rst_blank", 32'(blank), 0);
        check_val("mid_rst_valid", 32'(digit_valid), 0);
        model_reset();
        repeat (2) @(posedge clock);
        model_commit(codes[9]);
        @(negedge clock);
        reset = 1'b1;
        measure_latency(lat);
        check_val("post_rst_latency", 32'(lat), 5);
        end_of_test("mid_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
